// File: rtl/mem_port_arbiter_if.sv
// Port bundle between the arbiter, the load queue / store buffer heads and the data-memory port.
// The arbiter connects through modport master; the surrounding pipeline and memory use modport slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5,
  parameter int PHY_WIDTH  = 6
) ();
  logic                  flush;
  logic                  ld_req_valid;
  logic                  ld_req_ready;
  logic [ADDR_WIDTH-1:0] ld_req_addr;
  logic [2:0]            ld_req_funct3;
  logic [31:0]           ld_req_age;
  logic [ROB_WIDTH-1:0]  ld_req_rob_id;
  logic [PHY_WIDTH-1:0]  ld_req_rd_phy;
  logic                  st_req_valid;
  logic                  st_req_ready;
  logic [ADDR_WIDTH-1:0] st_req_addr;
  logic [DATA_WIDTH-1:0] st_req_data;
  logic [2:0]            st_req_funct3;
  logic [31:0]           st_req_age;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_funct3;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  ld_resp_valid;
  logic [DATA_WIDTH-1:0] ld_resp_data;
  logic [ROB_WIDTH-1:0]  ld_resp_rob_id;
  logic [PHY_WIDTH-1:0]  ld_resp_rd_phy;
  logic                  st_done;

  modport master (
    input  flush,
    input  ld_req_valid, ld_req_addr, ld_req_funct3, ld_req_age, ld_req_rob_id, ld_req_rd_phy,
    output ld_req_ready,
    input  st_req_valid, st_req_addr, st_req_data, st_req_funct3, st_req_age,
    output st_req_ready,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_funct3,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ld_resp_valid, ld_resp_data, ld_resp_rob_id, ld_resp_rd_phy, st_done
  );

  modport slave (
    output flush,
    output ld_req_valid, ld_req_addr, ld_req_funct3, ld_req_age, ld_req_rob_id, ld_req_rd_phy,
    input  ld_req_ready,
    output st_req_valid, st_req_addr, st_req_data, st_req_funct3, st_req_age,
    input  st_req_ready,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_funct3,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ld_resp_valid, ld_resp_data, ld_resp_rob_id, ld_resp_rd_phy, st_done
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Oldest-first arbiter sharing one data-memory port between load issue and store drain, one transaction in flight.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_WIDTH    = 5,
  parameter int PHY_WIDTH    = 6,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY_LD, BUSY_ST} state_t;

  state_t                state_q, state_d;
  logic [ROB_WIDTH-1:0]  rob_q, rob_d;
  logic [PHY_WIDTH-1:0]  phy_q, phy_d;
  logic                  drop_q, drop_d;
  logic                  ld_resp_valid_q, ld_resp_valid_d;
  logic [DATA_WIDTH-1:0] ld_resp_data_q, ld_resp_data_d;
  logic                  st_done_q, st_done_d;

  logic ld_elig, st_elig, sel_ld, sel_st, ld_wins;
  logic ld_hs, st_hs;

  // Wrap-safe age compare: a is older than b when the signed difference is negative.
  function automatic logic is_older(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] diff;
    diff = signed'(a - b);
    return diff < 0;
  endfunction

  assign ld_elig = bus.ld_req_valid && !bus.flush;
  assign st_elig = bus.st_req_valid;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
  logic       ld_starved, st_starved;

  assign ld_starved = ld_cnt_q >= LIMIT;
  assign st_starved = st_cnt_q >= LIMIT;
  // A starved store beats a starved load; otherwise fall back to age, ties to the store.
  assign ld_wins    = st_starved ? 1'b0 :
                      ld_starved ? 1'b1 : is_older(bus.ld_req_age, bus.st_req_age);
`else
  assign ld_wins    = is_older(bus.ld_req_age, bus.st_req_age);
`endif

  assign sel_ld = ld_elig && (!st_elig || ld_wins);
  assign sel_st = st_elig && !sel_ld;
  assign ld_hs  = (state_q == IDLE) && !rst && sel_ld && bus.mem_req_ready;
  assign st_hs  = (state_q == IDLE) && !rst && sel_st && bus.mem_req_ready;

`ifdef MEM_ARB_STARVE_GUARD_EN
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    st_cnt_d = st_cnt_q;
    if (ld_hs) begin
      ld_cnt_d = '0;
    end else if ((state_q == IDLE) && ld_elig && !sel_ld && (ld_cnt_q != 4'hF)) begin
      ld_cnt_d = ld_cnt_q + 4'd1;
    end
    if (st_hs) begin
      st_cnt_d = '0;
    end else if ((state_q == IDLE) && st_elig && !sel_st && (st_cnt_q != 4'hF)) begin
      st_cnt_d = st_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d         = state_q;
    rob_d           = rob_q;
    phy_d           = phy_q;
    drop_d          = drop_q;
    ld_resp_valid_d = 1'b0;
    ld_resp_data_d  = ld_resp_data_q;
    st_done_d       = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_funct3    = '0;
    bus.ld_req_ready  = 1'b0;
    bus.st_req_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Port is held quiet while reset is asserted so no request can be accepted and lost.
        if (!rst) begin
          bus.mem_req_valid = ld_elig || st_elig;
          if (sel_st) begin
            bus.mem_we       = 1'b1;
            bus.mem_addr     = bus.st_req_addr;
            bus.mem_wdata    = bus.st_req_data;
            bus.mem_funct3   = bus.st_req_funct3;
            bus.st_req_ready = bus.mem_req_ready;
          end else if (sel_ld) begin
            bus.mem_addr     = bus.ld_req_addr;
            bus.mem_funct3   = bus.ld_req_funct3;
            bus.ld_req_ready = bus.mem_req_ready;
          end
        end
        if (st_hs) begin
          state_d = BUSY_ST;
        end else if (ld_hs) begin
          state_d = BUSY_LD;
          rob_d   = bus.ld_req_rob_id;
          phy_d   = bus.ld_req_rd_phy;
          drop_d  = 1'b0;
        end
      end
      BUSY_LD: begin
        if (bus.flush) drop_d = 1'b1;
        if (bus.mem_resp_valid) begin
          state_d         = IDLE;
          drop_d          = 1'b0;
          ld_resp_valid_d = !(drop_q || bus.flush);
          ld_resp_data_d  = bus.mem_rdata;
        end
      end
      BUSY_ST: begin
        if (bus.mem_resp_valid) begin
          state_d   = IDLE;
          st_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rob_q           <= '0;
      phy_q           <= '0;
      drop_q          <= 1'b0;
      ld_resp_valid_q <= 1'b0;
      ld_resp_data_q  <= '0;
      st_done_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rob_q           <= rob_d;
      phy_q           <= phy_d;
      drop_q          <= drop_d;
      ld_resp_valid_q <= ld_resp_valid_d;
      ld_resp_data_q  <= ld_resp_data_d;
      st_done_q       <= st_done_d;
    end
  end

  assign bus.ld_resp_valid  = ld_resp_valid_q;
  assign bus.ld_resp_data   = ld_resp_data_q;
  assign bus.ld_resp_rob_id = rob_q;
  assign bus.ld_resp_rd_phy = phy_q;
  assign bus.st_done        = st_done_q;

endmodule
